counter_updown_mod: RTL and testbench

//  Parametrised successor to the fixed 4-bit up-counter: modulo-N up/down counter

---
 rtl/counter_updown_mod.sv | 81 ++++++++
 tb/tb_counter_updown_mod.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Modulo-N up/down counter with synchronous load, count enable,
//            and a selectable wrap or saturate behaviour at the range ends.
//            tc predicts the next-edge wrap/saturation for cascading stages.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_mod #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,        // asynchronous, active-low
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped,
   output logic             saturated
);

   // Highest legal count value; MODULUS <= 2**WIDTH so this always fits.
   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
   // Load clamp threshold compared one bit wider so MODULUS == 2**WIDTH works.
   localparam logic [WIDTH:0]   MOD_WIDE  = (WIDTH+1)'(MODULUS);
   localparam bit               SAT_MODE  = (SATURATE != 0);

   logic             at_top;
   logic             at_bottom;
   logic             load_too_big;
   logic [WIDTH-1:0] load_clamped;

   // Range-end decode and load clamp, shared by tc and the counter update.
   always_comb begin
      at_top       = (count == MAX_COUNT);
      at_bottom    = (count == '0);
      load_too_big = ({1'b0, load_value} >= MOD_WIDE);
      load_clamped = load_too_big ? MAX_COUNT : load_value;
   end

   // Terminal count: the next enabled step will wrap or saturate.
   assign tc = en & ~load & ((up & at_top) | (~up & at_bottom));

   // Counter state with priority reset > load > en > hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         wrapped   <= 1'b0;
         saturated <= 1'b0;
      end else if (load) begin
         count     <= load_clamped;
         wrapped   <= 1'b0;
         saturated <= 1'b0;
      end else if (en) begin
         if (up ? at_top : at_bottom) begin
            // Boundary step: either hold at the end or jump to the other end.
            if (SAT_MODE) begin
               wrapped   <= 1'b0;
               saturated <= 1'b1;
            end else begin
               count     <= up ? '0 : MAX_COUNT;
               wrapped   <= 1'b1;
               saturated <= 1'b0;
            end
         end else begin
            count     <= up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
            wrapped   <= 1'b0;
            saturated <= 1'b0;
         end
      end else begin
         // Idle: count and saturation level hold, the wrap pulse ends.
         wrapped <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_updown_mod
// Purpose  : Directed self-checking bench for counter_updown_mod. Three
//            instances cover default wrap (mod 16), mod-10 wrap and mod-10
//            saturate configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_updown_mod;

   logic       clk;
   logic       reset;
   logic       en0, up0, load0;
   logic [3:0] lv0, count0;
   logic       tc0, wr0, sat0;
   logic       en1, up1, load1;
   logic [3:0] lv1, count1;
   logic       tc1, wr1, sat1;
   logic       en2, up2, load2;
   logic [3:0] lv2, count2;
   logic       tc2, wr2, sat2;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   counter_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut0 (
      .clk(clk), .reset(reset), .en(en0), .up(up0), .load(load0),
      .load_value(lv0), .count(count0), .tc(tc0), .wrapped(wr0), .saturated(sat0));

   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut1 (
      .clk(clk), .reset(reset), .en(en1), .up(up1), .load(load1),
      .load_value(lv1), .count(count1), .tc(tc1), .wrapped(wr1), .saturated(sat1));

   counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut2 (
      .clk(clk), .reset(reset), .en(en2), .up(up2), .load(load2),
      .load_value(lv2), .count(count2), .tc(tc2), .wrapped(wr2), .saturated(sat2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      en0 = 1'b1; up0 = 1'b1; load0 = 1'b0; lv0 = 4'd0;
      en1 = 1'b0; up1 = 1'b1; load1 = 1'b0; lv1 = 4'd0;
      en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; lv2 = 4'd0;
      #50;
      chk_cnt++;
      if (count0 !== 4'd0) $display("FAIL reset_count0 got %0d exp 0", count0); else pass_cnt++;
      chk_cnt++;
      if (wr0 !== 1'b0) $display("FAIL reset_wrapped0 got %b exp 0", wr0); else pass_cnt++;
      chk_cnt++;
      if (sat2 !== 1'b0) $display("FAIL reset_saturated2 got %b exp 0", sat2); else pass_cnt++;
      chk_cnt++;
      if (count1 !== 4'd0 || count2 !== 4'd0)
         $display("FAIL reset_count12 got %0d/%0d exp 0/0", count1, count2);
      else pass_cnt++;
      #50;
      reset = 1'b1;
      #1;
      chk_cnt++;
      if (tc0 !== 1'b0) $display("FAIL reset_tc0 got %b exp 0", tc0); else pass_cnt++;
   endtask

   // Default mod-16 wrap: 1..15 then 0 with a wrap pulse.
   task automatic test_wrap_up();
      logic [3:0] exp_c;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp_c = 4'(i % 16);
         chk_cnt++;
         if (count0 !== exp_c) $display("FAIL up_count step %0d got %0d exp %0d", i, count0, exp_c); else pass_cnt++;
         chk_cnt++;
         if (wr0 !== (i == 16)) $display("FAIL up_wrapped step %0d got %b exp %b", i, wr0, (i == 16)); else pass_cnt++;
         chk_cnt++;
         if (tc0 !== (exp_c == 4'd15)) $display("FAIL up_tc step %0d got %b exp %b", i, tc0, (exp_c == 4'd15)); else pass_cnt++;
      end
      en0 = 1'b0;
   endtask

   // Mod-10 counting down from 0: 9 (wrap), 8 .. 0.
   task automatic test_wrap_down();
      logic [3:0] exp_c;
      en1 = 1'b1; up1 = 1'b0;
      #1;
      chk_cnt++;
      if (tc1 !== 1'b1) $display("FAIL down_tc_at0 got %b exp 1", tc1); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         tick();
         exp_c = 4'(9 - i);
         chk_cnt++;
         if (count1 !== exp_c) $display("FAIL down_count step %0d got %0d exp %0d", i, count1, exp_c); else pass_cnt++;
         chk_cnt++;
         if (wr1 !== (i == 0)) $display("FAIL down_wrapped step %0d got %b exp %b", i, wr1, (i == 0)); else pass_cnt++;
         chk_cnt++;
         if (tc1 !== (exp_c == 4'd0)) $display("FAIL down_tc step %0d got %b exp %b", i, tc1, (exp_c == 4'd0)); else pass_cnt++;
      end
      en1 = 1'b0;
   endtask

   // Mod-10 saturate: from 7 up gives 8,9,9,9 then down gives 8.
   task automatic test_saturate();
      logic [3:0] exp_c [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
      logic       exp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      load2 = 1'b1; lv2 = 4'd7;
      tick();
      chk_cnt++;
      if (count2 !== 4'd7) $display("FAIL sat_load7 got %0d exp 7", count2); else pass_cnt++;
      load2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_cnt++;
         if (count2 !== exp_c[i]) $display("FAIL sat_count step %0d got %0d exp %0d", i, count2, exp_c[i]); else pass_cnt++;
         chk_cnt++;
         if (sat2 !== exp_s[i]) $display("FAIL sat_level step %0d got %b exp %b", i, sat2, exp_s[i]); else pass_cnt++;
         chk_cnt++;
         if (wr2 !== 1'b0) $display("FAIL sat_wrapped step %0d got %b exp 0", i, wr2); else pass_cnt++;
      end
      chk_cnt++;
      if (tc2 !== 1'b1) $display("FAIL sat_tc_at9 got %b exp 1", tc2); else pass_cnt++;
      up2 = 1'b0;
      tick();
      chk_cnt++;
      if (count2 !== 4'd8) $display("FAIL sat_down_count got %0d exp 8", count2); else pass_cnt++;
      chk_cnt++;
      if (sat2 !== 1'b0) $display("FAIL sat_down_level got %b exp 0", sat2); else pass_cnt++;
      en2 = 1'b0;
   endtask

   // Direction flip applies on the very edge it is sampled.
   task automatic test_back_to_back();
      en1 = 1'b1; up1 = 1'b0;
      tick();
      chk_cnt++;
      if (count1 !== 4'd9 || wr1 !== 1'b1) $display("FAIL b2b_down got %0d/%b exp 9/1", count1, wr1); else pass_cnt++;
      up1 = 1'b1;
      tick();
      chk_cnt++;
      if (count1 !== 4'd0 || wr1 !== 1'b1) $display("FAIL b2b_up_wrap got %0d/%b exp 0/1", count1, wr1); else pass_cnt++;
      tick();
      chk_cnt++;
      if (count1 !== 4'd1 || wr1 !== 1'b0) $display("FAIL b2b_up_step got %0d/%b exp 1/0", count1, wr1); else pass_cnt++;
      en1 = 1'b0;
      tick();
      chk_cnt++;
      if (count1 !== 4'd1 || wr1 !== 1'b0) $display("FAIL b2b_hold got %0d/%b exp 1/0", count1, wr1); else pass_cnt++;
   endtask

   // Load beats enable; out-of-range load clamps to MODULUS-1.
   task automatic test_load();
      load1 = 1'b1; lv1 = 4'd5; en1 = 1'b1; up1 = 1'b1;
      tick();
      chk_cnt++;
      if (count1 !== 4'd5) $display("FAIL load5 got %0d exp 5", count1); else pass_cnt++;
      lv1 = 4'd14;
      tick();
      chk_cnt++;
      if (count1 !== 4'd9) $display("FAIL load14_clamp got %0d exp 9", count1); else pass_cnt++;
      chk_cnt++;
      if (tc1 !== 1'b0) $display("FAIL load_masks_tc got %b exp 0", tc1); else pass_cnt++;
      load1 = 1'b0;
      #1;
      chk_cnt++;
      if (tc1 !== 1'b1) $display("FAIL tc_after_load got %b exp 1", tc1); else pass_cnt++;
      tick();
      chk_cnt++;
      if (count1 !== 4'd0 || wr1 !== 1'b1) $display("FAIL wrap_after_load got %0d/%b exp 0/1", count1, wr1); else pass_cnt++;
      en1 = 1'b0;
      load0 = 1'b1; lv0 = 4'd14;
      tick();
      chk_cnt++;
      if (count0 !== 4'd14) $display("FAIL load14_mod16 got %0d exp 14", count0); else pass_cnt++;
      load0 = 1'b0;
   endtask

   // Disabled counter holds value with no wrap pulse and no tc.
   task automatic test_hold();
      load0 = 1'b1; lv0 = 4'd6; en0 = 1'b0;
      tick();
      load0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_cnt++;
         if (count0 !== 4'd6) $display("FAIL hold_count cyc %0d got %0d exp 6", i, count0); else pass_cnt++;
         chk_cnt++;
         if (wr0 !== 1'b0 || tc0 !== 1'b0) $display("FAIL hold_wr_tc cyc %0d got %b/%b exp 0/0", i, wr0, tc0); else pass_cnt++;
      end
   endtask

   // Short asynchronous reset pulse between edges clears immediately.
   task automatic test_async_reset();
      load0 = 1'b1; lv0 = 4'd11; en0 = 1'b0;
      tick();
      load0 = 1'b0;
      chk_cnt++;
      if (count0 !== 4'd11) $display("FAIL areset_pre got %0d exp 11", count0); else pass_cnt++;
      #1;
      reset = 1'b0;
      #1;
      chk_cnt++;
      if (count0 !== 4'd0) $display("FAIL areset_immediate got %0d exp 0", count0); else pass_cnt++;
      #2;
      reset = 1'b1;
      en0 = 1'b1; up0 = 1'b1;
      tick();
      chk_cnt++;
      if (count0 !== 4'd1) $display("FAIL areset_resume1 got %0d exp 1", count0); else pass_cnt++;
      tick();
      chk_cnt++;
      if (count0 !== 4'd2) $display("FAIL areset_resume2 got %0d exp 2", count0); else pass_cnt++;
      en0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_back_to_back();
      test_load();
      test_hold();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
